// File: rtl/capture_pkg.sv
// Shared definitions for the capture buffer write path: FSM encodings,
// capture mode constants and a small state-classification helper.
package capture_pkg;

  localparam logic [2:0] CAP_IDLE  = 3'd0;
  localparam logic [2:0] CAP_FILL  = 3'd1;
  localparam logic [2:0] CAP_ARMED = 3'd2;
  localparam logic [2:0] CAP_POST  = 3'd3;
  localparam logic [2:0] CAP_DONE  = 3'd4;

  localparam logic CAP_MODE_ONESHOT = 1'b0;
  localparam logic CAP_MODE_RING    = 1'b1;

  // States in which incoming samples are written to the RAM.
  function automatic logic cap_writes(input logic [2:0] state);
    return (state == CAP_FILL) || (state == CAP_ARMED) || (state == CAP_POST);
  endfunction

endpackage

// File: rtl/cap_addr_ctr.sv
// Modulo-DEPTH write address counter; wrap pulses on the increment that
// takes the address from DEPTH-1 back to 0.
module cap_addr_ctr #(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 32768
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] r_addr;

  // Compare against DEPTH-1 so non-power-of-two depths wrap correctly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr <= '0;
    end else if (clr) begin
      r_addr <= '0;
    end else if (inc) begin
      r_addr <= (r_addr == LAST) ? '0 : r_addr + ADDR_W'(1);
    end
  end

  assign addr = r_addr;
  assign wrap = inc && (r_addr == LAST);

endmodule

// File: rtl/capture_wr_ctrl.sv
// Write-side controller for the ADC capture RAM: one-shot fill or circular
// pre-trigger recording with a programmable post-trigger length.
module capture_wr_ctrl
  import capture_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 32768
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rf_capture_start,
  input  logic              rf_capture_abort,
  input  logic              rf_mode,
  input  logic [ADDR_W-1:0] rf_post_len,
  input  logic              trig,
  input  logic              write_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] waddr,
  output logic              busy,
  output logic              wr_done,
  output logic              wrapped,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] oldest_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [2:0]        r_state;
  logic              r_mode_q;
  logic [ADDR_W-1:0] r_post_q;
  logic [ADDR_W-1:0] r_post_cnt;
  logic [ADDR_W-1:0] r_trig_addr;
  logic              r_wrapped;
  logic              r_done;

  logic              w_clr;
  logic              w_inc;
  logic              w_wrap;
  logic [ADDR_W-1:0] w_waddr;
  logic [ADDR_W-1:0] w_post_clamped;

  assign mem_we         = write_en & cap_writes(r_state);
  assign w_clr          = rf_capture_abort | rf_capture_start;
  assign w_inc          = mem_we & ~w_clr;
  assign w_post_clamped = (rf_post_len > LAST) ? LAST : rf_post_len;

  cap_addr_ctr #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_addr_ctr (
    .clk  (clk),
    .rstn (rstn),
    .clr  (w_clr),
    .inc  (w_inc),
    .addr (w_waddr),
    .wrap (w_wrap)
  );

  // Abort beats start beats normal sequencing; a write in the final FILL
  // slot or the last POST slot lands in DONE on the following edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= CAP_IDLE;
      r_mode_q    <= CAP_MODE_ONESHOT;
      r_post_q    <= '0;
      r_post_cnt  <= '0;
      r_trig_addr <= '0;
      r_wrapped   <= 1'b0;
      r_done      <= 1'b0;
    end else if (rf_capture_abort) begin
      r_state   <= CAP_IDLE;
      r_wrapped <= 1'b0;
      r_done    <= 1'b0;
    end else if (rf_capture_start) begin
      r_state   <= (rf_mode == CAP_MODE_RING) ? CAP_ARMED : CAP_FILL;
      r_mode_q  <= rf_mode;
      r_post_q  <= w_post_clamped;
      r_wrapped <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (w_wrap) begin
        r_wrapped <= 1'b1;
      end
      case (r_state)
        CAP_FILL: begin
          if (w_wrap) begin
            r_state <= CAP_DONE;
            r_done  <= 1'b1;
          end
        end
        CAP_ARMED: begin
          if (trig && (r_mode_q == CAP_MODE_RING)) begin
            r_trig_addr <= w_waddr;
            r_post_cnt  <= r_post_q;
            if (r_post_q != '0) begin
              r_state <= CAP_POST;
            end else begin
              r_state <= CAP_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        CAP_POST: begin
          if (mem_we) begin
            if (r_post_cnt != '0) begin
              r_post_cnt <= r_post_cnt - ADDR_W'(1);
            end
            if (r_post_cnt == ADDR_W'(1)) begin
              r_state <= CAP_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign waddr       = w_waddr;
  assign busy        = cap_writes(r_state);
  assign wr_done     = r_done;
  assign wrapped     = r_wrapped;
  assign trig_addr   = r_trig_addr;
  assign oldest_addr = r_wrapped ? w_waddr : '0;

endmodule

// File: tb/tb_capture_wr_ctrl.sv
// Randomised and directed bench for capture_wr_ctrl: two instances (DEPTH 16
// and DEPTH 12) share stimulus and are compared against a sample-count model.
module tb_capture_wr_ctrl;

  logic       clk;
  logic       rstn;
  logic       rf_capture_start;
  logic       rf_capture_abort;
  logic       rf_mode;
  logic [3:0] rf_post_len;
  logic       trig;
  logic       write_en;

  logic       memWe[2];
  logic       busyO[2];
  logic       doneO[2];
  logic       wrappedO[2];
  logic [3:0] waddrO[2];
  logic [3:0] trigAddrO[2];
  logic [3:0] oldestO[2];

  int testCount = 0;
  int failCount = 0;

  // Model: phase 0 idle, 1 recording (fill or pre-trigger), 2 post-trigger, 3 done.
  int depth[2] = '{16, 12};
  int phase[2];
  int nW[2];
  int postLen[2];
  int postLeft[2];
  int trigAddr[2];
  bit oneShot[2];
  bit doneF[2];

  capture_wr_ctrl #(.ADDR_W(4), .DEPTH(16)) dut16 (
    .clk              (clk),
    .rstn             (rstn),
    .rf_capture_start (rf_capture_start),
    .rf_capture_abort (rf_capture_abort),
    .rf_mode          (rf_mode),
    .rf_post_len      (rf_post_len),
    .trig             (trig),
    .write_en         (write_en),
    .mem_we           (memWe[0]),
    .waddr            (waddrO[0]),
    .busy             (busyO[0]),
    .wr_done          (doneO[0]),
    .wrapped          (wrappedO[0]),
    .trig_addr        (trigAddrO[0]),
    .oldest_addr      (oldestO[0])
  );

  capture_wr_ctrl #(.ADDR_W(4), .DEPTH(12)) dut12 (
    .clk              (clk),
    .rstn             (rstn),
    .rf_capture_start (rf_capture_start),
    .rf_capture_abort (rf_capture_abort),
    .rf_mode          (rf_mode),
    .rf_post_len      (rf_post_len),
    .trig             (trig),
    .write_en         (write_en),
    .mem_we           (memWe[1]),
    .waddr            (waddrO[1]),
    .busy             (busyO[1]),
    .wr_done          (doneO[1]),
    .wrapped          (wrappedO[1]),
    .trig_addr        (trigAddrO[1]),
    .oldest_addr      (oldestO[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      phase[k] = 0; nW[k] = 0; postLen[k] = 0; postLeft[k] = 0;
      trigAddr[k] = 0; oneShot[k] = 1'b0; doneF[k] = 1'b0;
    end
  endtask

  task automatic checkAll();
    for (int k = 0; k < 2; k++) begin
      bit active;
      bit wrp;
      int wa;
      active = (phase[k] == 1) || (phase[k] == 2);
      wa     = nW[k] % depth[k];
      wrp    = nW[k] >= depth[k];
      checkOutput($sformatf("mem_we[D%0d]", depth[k]), 32'(memWe[k]), 32'(active && write_en));
      checkOutput($sformatf("waddr[D%0d]", depth[k]), 32'(waddrO[k]), 32'(wa));
      checkOutput($sformatf("busy[D%0d]", depth[k]), 32'(busyO[k]), 32'(active));
      checkOutput($sformatf("wr_done[D%0d]", depth[k]), 32'(doneO[k]), 32'(doneF[k]));
      checkOutput($sformatf("wrapped[D%0d]", depth[k]), 32'(wrappedO[k]), 32'(wrp));
      checkOutput($sformatf("trig_addr[D%0d]", depth[k]), 32'(trigAddrO[k]), 32'(trigAddr[k]));
      checkOutput($sformatf("oldest[D%0d]", depth[k]), 32'(oldestO[k]), 32'(wrp ? wa : 0));
    end
  endtask

  task automatic modelStep(input bit st, input bit ab, input bit md, input int pl,
                           input bit tg, input bit we);
    for (int k = 0; k < 2; k++) begin
      if (ab) begin
        phase[k] = 0; nW[k] = 0; doneF[k] = 1'b0;
      end else if (st) begin
        phase[k]   = 1;
        oneShot[k] = !md;
        postLen[k] = (pl > depth[k] - 1) ? depth[k] - 1 : pl;
        nW[k]      = 0;
        doneF[k]   = 1'b0;
      end else if (phase[k] == 1 && oneShot[k]) begin
        if (we) nW[k]++;
        if (nW[k] == depth[k]) begin
          phase[k] = 3; doneF[k] = 1'b1;
        end
      end else if (phase[k] == 1) begin
        if (tg) begin
          trigAddr[k] = nW[k] % depth[k];
          if (we) nW[k]++;
          if (postLen[k] == 0) begin
            phase[k] = 3; doneF[k] = 1'b1;
          end else begin
            phase[k] = 2; postLeft[k] = postLen[k];
          end
        end else if (we) begin
          nW[k]++;
        end
      end else if (phase[k] == 2) begin
        if (we) begin
          nW[k]++;
          postLeft[k]--;
          if (postLeft[k] == 0) begin
            phase[k] = 3; doneF[k] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit st, input bit ab, input bit md, input int pl,
                               input bit tg, input bit we);
    @(negedge clk);
    rf_capture_start = st;
    rf_capture_abort = ab;
    rf_mode          = md;
    rf_post_len      = 4'(pl);
    trig             = tg;
    write_en         = we;
    #1;
    checkAll();
    @(posedge clk);
    modelStep(st, ab, md, pl, tg, we);
  endtask

  task automatic runWrites(input int n, input bit we);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, we);
  endtask

  initial begin
    rstn = 1'b0;
    rf_capture_start = 1'b0; rf_capture_abort = 1'b0; rf_mode = 1'b0;
    rf_post_len = 4'd0; trig = 1'b0; write_en = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAll();
    rstn = 1'b1;

    // One-shot fill, write_en held high
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    runWrites(20, 1'b1);

    // One-shot fill with write_en toggling
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 34; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, (i % 2) == 0);

    // Ring, post_len 4, trigger after 20 writes
    applyStimulus(1'b1, 1'b0, 1'b1, 4, 1'b0, 1'b0);
    runWrites(20, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    runWrites(6, 1'b1);
    @(negedge clk);
    checkOutput("ringTrigAddr", 32'(trigAddrO[0]), 32'd4);
    checkOutput("ringWaddr", 32'(waddrO[0]), 32'd9);
    checkOutput("ringOldest", 32'(oldestO[0]), 32'd9);
    checkOutput("ringDone", 32'(doneO[0]), 32'd1);

    // Ring, post_len 0
    applyStimulus(1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    runWrites(3, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    runWrites(2, 1'b1);

    // Ring, post_len clamped to DEPTH-1
    applyStimulus(1'b1, 1'b0, 1'b1, 15, 1'b0, 1'b0);
    runWrites(3, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    runWrites(20, 1'b1);

    // Early trigger, no wrap
    applyStimulus(1'b1, 1'b0, 1'b1, 4, 1'b0, 1'b0);
    runWrites(5, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    runWrites(6, 1'b1);
    @(negedge clk);
    checkOutput("earlyWrapped", 32'(wrappedO[0]), 32'd0);
    checkOutput("earlyOldest", 32'(oldestO[0]), 32'd0);
    checkOutput("earlyTrigAddr", 32'(trigAddrO[0]), 32'd5);

    // Start and trig together, then restart during POST
    applyStimulus(1'b1, 1'b0, 1'b1, 8, 1'b1, 1'b1);
    runWrites(4, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    runWrites(2, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    runWrites(3, 1'b1);

    // Abort with start
    applyStimulus(1'b1, 1'b1, 1'b1, 3, 1'b0, 1'b1);
    runWrites(2, 1'b1);
    @(negedge clk);
    checkOutput("abortBusy", 32'(busyO[0]), 32'd0);

    // Asynchronous reset mid-fill at waddr 7
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    runWrites(7, 1'b1);
    @(negedge clk);
    rf_capture_start = 1'b0; rf_capture_abort = 1'b0; trig = 1'b0;
    write_en = 1'b1;
    #1;
    checkOutput("preResetWaddr", 32'(waddrO[0]), 32'd7);
    #1;
    rstn = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    write_en = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    runWrites(18, 1'b1);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(99) < 3, $urandom_range(99) < 2, 1'($urandom_range(1)),
                    int'($urandom_range(15)), $urandom_range(99) < 8,
                    $urandom_range(99) < 70);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
